shift_pipe_scheduler: RTL and testbench
=======================================

// Module: shift_pipe_scheduler
// PURPOSE
//  Round-robin scheduler that shares one LENGTH-deep, WIDTH-bit shift pipeline between NREQ requesters.
//  Accepts at most one beat per cycle via valid/ready and tags each beat with its requester ID.
//  The beat and its ID shift through the pipeline together; out_valid/out_ready provide downstream backpressure.
//  Sits in front of the existing shift-register datapath and owns its stall/enable sequencing.
// PARAMETERS
//  WIDTH   8  data width per beat
//  LENGTH  4  pipeline depth in stages (>=1)
//  NREQ    4  number of requesters (>=1); localparam IDW = max(1,$clog2(NREQ)), OCCW = $clog2(LENGTH+1)
// PORTS
//  clock      in   1           rising-edge clock
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   NREQ        requester k has a beat
//  req_data   in   NREQ*WIDTH  requester k data at [k*WIDTH +: WIDTH]
//  req_ready  out  NREQ        one-hot grant; transfer when req_valid[k] & req_ready[k]
//  out_valid  out  1           last stage holds a valid beat
//  out_data   out  WIDTH       last-stage data
//  out_id     out  IDW         last-stage requester ID
//  out_ready  in   1           downstream accepts the beat
//  occupancy  out  OCCW        number of valid stages (0..LENGTH)
//  busy       out  1           occupancy != 0
// BEHAVIOUR
//  - State: LENGTH stages of {valid,id,data}; round-robin pointer ptr (0..NREQ-1); occupancy counter.
//  - Reset (sync, highest priority): all stage valid/id/data=0, ptr=0, occupancy=0.
//    Outputs during and after reset: out_valid=0, out_data=0, out_id=0, busy=0, req_ready=0 while reset=1.
//  - advance = !out_valid | out_ready (combinational); the whole pipeline moves only when advance=1.
//  - Grant (combinational): first k with req_valid[k]=1, searching ptr, ptr+1, ... mod NREQ.
//    req_ready[k]=1 only for the granted k and only when advance=1 and reset=0. req_ready may depend on req_valid.
//  - On an advance edge: stage[i] <= stage[i-1]; stage[0] <= {1,grant_id,req_data[grant]} if any req_valid.
//    Otherwise stage[0] <= bubble {0,0,0}. Bubbles are not compressed.
//  - ptr <= grant_id+1 (mod NREQ) only on an accepted transfer; unchanged otherwise.
//  - Latency: a beat accepted on edge E is on out_* after edge E+LENGTH-1, given no stall.
//    With LENGTH=1 it is visible immediately after the accepting edge.
//  - Stall (out_valid & !out_ready): no stage changes, out_data/out_id held stable, all req_ready=0, ptr unchanged.
//  - occupancy: +1 on accept, -1 on output transfer (out_valid & out_ready), unchanged if both or neither occur.
//    occupancy never exceeds LENGTH.
//  - Invalid stages always carry data=0, id=0, so out_data/out_id=0 whenever out_valid=0.
//  - Ordering: beats leave in acceptance order; no loss and no duplication under any valid/ready pattern.
//  - NREQ=1: grant is always requester 0, and out_id=0.
// TESTING (WIDTH=8, LENGTH=4, NREQ=4 unless noted)
//  1 Reset: reset=1 for 2 edges with req_valid=4'hF -> req_ready=0, out_valid=0, out_data=00, occupancy=0.
//  2 Single source: req 2 streams 01,12,23,... with out_ready=1 -> req_ready[2]=1 every cycle.
//    First beat 01 (out_id=2) appears 3 edges after its accept edge, followed by 12, 23, ... with no gaps.
//  3 Round robin: req_valid=4'hF, req k data=A0+k constant -> out_id sequence 0,1,2,3,0,1,...
//    out_data sequence A0,A1,A2,A3,...
//  4 Backpressure: drop out_ready for 3 cycles while out_valid=1 -> out_data/out_id frozen, req_ready=0, occupancy=4.
//    On release the stream resumes with no lost or repeated beats.
//  5 Bubbles: only req 1, valid on alternate cycles, out_ready=1 -> out_valid toggles 1,0,1,0.
//    occupancy settles at 2, and out_data=00 on the gap cycles.
//  6 Mid-op reset: occupancy=4, one-cycle reset -> next cycle out_valid=0, occupancy=0.
//    With req_valid=4'hF, the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/shift_pipe_scheduler.sv
// Round-robin front end sharing one LENGTH-deep shift pipeline between NREQ requesters.
// Each beat travels with its requester ID; the whole pipe stalls on downstream backpressure.
module shift_pipe_scheduler #(
    parameter int unsigned  WIDTH  = 8,
    parameter int unsigned  LENGTH = 4,
    parameter int unsigned  NREQ   = 4,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned OCCW   = $clog2(LENGTH + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDW-1:0]          out_id,
    input  logic                    out_ready,
    output logic [OCCW-1:0]         occupancy,
    output logic                    busy
);

    logic                 valid_q [LENGTH];
    logic                 valid_d [LENGTH];
    logic [IDW-1:0]       id_q    [LENGTH];
    logic [IDW-1:0]       id_d    [LENGTH];
    logic [WIDTH-1:0]     data_q  [LENGTH];
    logic [WIDTH-1:0]     data_d  [LENGTH];
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [OCCW-1:0]      occ_q, occ_d;
    logic                 busy_q, busy_d;

    logic [2*NREQ-1:0]    rot_c;
    logic [IDW-1:0]       off_c;
    logic [IDW:0]         sum_c;
    logic [IDW-1:0]       gid_c;
    logic [WIDTH-1:0]     gdata_c;
    logic                 any_c;
    logic                 advance_c;
    logic                 accept_c;
    logic                 xfer_c;

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
    always_comb begin
        rot_c = (2*NREQ)'({req_valid, req_valid} >> ptr_q);
        any_c = 1'b0;
        off_c = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                any_c = 1'b1;
                off_c = IDW'(k);
            end
        end
        sum_c = (IDW+1)'(ptr_q) + (IDW+1)'(off_c);
        if (sum_c >= (IDW+1)'(NREQ)) begin
            sum_c = sum_c - (IDW+1)'(NREQ);
        end
        gid_c   = IDW'(sum_c);
        gdata_c = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gid_c == IDW'(k)) begin
                gdata_c = req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Handshake: the pipe only moves when the last stage is empty or draining.
    always_comb begin
        advance_c = !valid_q[LENGTH-1] || out_ready;
        accept_c  = any_c && advance_c && !reset;
        xfer_c    = valid_q[LENGTH-1] && out_ready && !reset;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = accept_c && (gid_c == IDW'(k));
        end
    end

    // Next state: shift on advance, bubbles enter stage 0 when nothing is granted.
    always_comb begin
        for (int i = 0; i < LENGTH; i++) begin
            valid_d[i] = valid_q[i];
            id_d[i]    = id_q[i];
            data_d[i]  = data_q[i];
        end
        ptr_d = ptr_q;
        if (advance_c) begin
            for (int i = LENGTH - 1; i > 0; i--) begin
                valid_d[i] = valid_q[i-1];
                id_d[i]    = id_q[i-1];
                data_d[i]  = data_q[i-1];
            end
            valid_d[0] = accept_c;
            id_d[0]    = accept_c ? gid_c : '0;
            data_d[0]  = accept_c ? gdata_c : '0;
        end
        if (accept_c) begin
            ptr_d = (gid_c == IDW'(NREQ - 1)) ? '0 : gid_c + IDW'(1);
        end
        occ_d  = occ_q + OCCW'(accept_c) - OCCW'(xfer_c);
        busy_d = (occ_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) begin
                valid_q[i] <= 1'b0;
                id_q[i]    <= '0;
                data_q[i]  <= '0;
            end
            ptr_q  <= '0;
            occ_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < LENGTH; i++) begin
                valid_q[i] <= valid_d[i];
                id_q[i]    <= id_d[i];
                data_q[i]  <= data_d[i];
            end
            ptr_q  <= ptr_d;
            occ_q  <= occ_d;
            busy_q <= busy_d;
        end
    end

    assign out_valid = valid_q[LENGTH-1];
    assign out_data  = data_q[LENGTH-1];
    assign out_id    = id_q[LENGTH-1];
    assign occupancy = occ_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shift_pipe_scheduler.sv
// Directed bench for shift_pipe_scheduler: vector table plus stall, bubble and
// single-stage/single-requester sequences.
module tb_shift_pipe_scheduler;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic [2:0]  occupancy;
    logic        busy;

    logic        r1_reset;
    logic [0:0]  r1_valid;
    logic [7:0]  r1_data;
    logic [0:0]  r1_ready;
    logic        r1_ovalid;
    logic [7:0]  r1_odata;
    logic [0:0]  r1_oid;
    logic        r1_oready;
    logic [0:0]  r1_occ;
    logic        r1_busy;

    int total = 0;
    int bad   = 0;

    shift_pipe_scheduler #(.WIDTH(8), .LENGTH(4), .NREQ(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .busy      (busy)
    );

    shift_pipe_scheduler #(.WIDTH(8), .LENGTH(1), .NREQ(1)) dut1 (
        .clock     (clock),
        .reset     (r1_reset),
        .req_valid (r1_valid),
        .req_data  (r1_data),
        .req_ready (r1_ready),
        .out_valid (r1_ovalid),
        .out_data  (r1_odata),
        .out_id    (r1_oid),
        .out_ready (r1_oready),
        .occupancy (r1_occ),
        .busy      (r1_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_oid;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; checks happen 1 time unit later.
    task automatic drive(input logic rst, input logic [3:0] rv, input logic [31:0] rd, input logic ordy);
        @(negedge clock);
        reset     = rst;
        req_valid = rv;
        req_data  = rd;
        out_ready = ordy;
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_rdy, input logic e_ov,
                             input logic [7:0] e_od, input logic [1:0] e_oid, input logic [2:0] e_occ);
        check({tag, " req_ready"}, 32'(req_ready), 32'(e_rdy));
        check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
        check({tag, " out_data"},  32'(out_data),  32'(e_od));
        check({tag, " out_id"},    32'(out_id),    32'(e_oid));
        check({tag, " occupancy"}, 32'(occupancy), 32'(e_occ));
        check({tag, " busy"},      32'(busy),      32'(e_occ != 3'd0));
    endtask

    task automatic drive1(input logic rv, input logic [7:0] rd, input logic ordy);
        @(negedge clock);
        r1_reset  = 1'b0;
        r1_valid  = rv;
        r1_data   = rd;
        r1_oready = ordy;
        #1;
    endtask

    task automatic check1(input string tag, input logic e_rdy, input logic e_ov,
                          input logic [7:0] e_od, input logic e_occ);
        check({tag, " req_ready"}, 32'(r1_ready),  32'(e_rdy));
        check({tag, " out_valid"}, 32'(r1_ovalid), 32'(e_ov));
        check({tag, " out_data"},  32'(r1_odata),  32'(e_od));
        check({tag, " out_id"},    32'(r1_oid),    32'd0);
        check({tag, " occupancy"}, 32'(r1_occ),    32'(e_occ));
    endtask

    initial begin
        // reset, single source on req 2, mid-op reset, round robin
        tbl[0]  = '{1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[1]  = '{1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[2]  = '{1'b0, 4'h4, 32'h00010000, 1'b1, 4'h4, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[3]  = '{1'b0, 4'h4, 32'h00120000, 1'b1, 4'h4, 1'b0, 8'h00, 2'd0, 3'd1};
        tbl[4]  = '{1'b0, 4'h4, 32'h00230000, 1'b1, 4'h4, 1'b0, 8'h00, 2'd0, 3'd2};
        tbl[5]  = '{1'b0, 4'h4, 32'h00340000, 1'b1, 4'h4, 1'b0, 8'h00, 2'd0, 3'd3};
        tbl[6]  = '{1'b0, 4'h4, 32'h00450000, 1'b1, 4'h4, 1'b1, 8'h01, 2'd2, 3'd4};
        tbl[7]  = '{1'b0, 4'h4, 32'h00560000, 1'b1, 4'h4, 1'b1, 8'h12, 2'd2, 3'd4};
        tbl[8]  = '{1'b0, 4'h4, 32'h00670000, 1'b1, 4'h4, 1'b1, 8'h23, 2'd2, 3'd4};
        tbl[9]  = '{1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h0, 1'b1, 8'h34, 2'd2, 3'd4};
        tbl[10] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0, 3'd0};
        tbl[11] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h2, 1'b0, 8'h00, 2'd0, 3'd1};
        tbl[12] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h4, 1'b0, 8'h00, 2'd0, 3'd2};
        tbl[13] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h8, 1'b0, 8'h00, 2'd0, 3'd3};
        tbl[14] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 3'd4};
        tbl[15] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h2, 1'b1, 8'hA1, 2'd1, 3'd4};
        tbl[16] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h4, 1'b1, 8'hA2, 2'd2, 3'd4};
        tbl[17] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h8, 1'b1, 8'hA3, 2'd3, 3'd4};
        tbl[18] = '{1'b0, 4'hF, 32'hA3A2A1A0, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 3'd4};

        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = 32'hA3A2A1A0;
        out_ready = 1'b1;
        r1_reset  = 1'b1;
        r1_valid  = 1'b0;
        r1_data   = 8'h00;
        r1_oready = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rd, tbl[i].ordy);
            check_all($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_od,
                      tbl[i].e_oid, tbl[i].e_occ);
        end

        // Stall with a full pipe: A1 (id 1) at the head, nothing may move.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'hF, 32'hA3A2A1A0, 1'b0);
            check_all($sformatf("stall%0d", c), 4'h0, 1'b1, 8'hA1, 2'd1, 3'd4);
        end

        // Release with no new requests: remaining beats drain in order.
        begin
            logic [7:0] exp_d   [5];
            logic [1:0] exp_id  [5];
            logic [2:0] exp_occ [5];
            exp_d   = '{8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'h00};
            exp_id  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
            exp_occ = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
            for (int c = 0; c < 5; c++) begin
                drive(1'b0, 4'h0, 32'h0, 1'b1);
                check_all($sformatf("drain%0d", c), 4'h0, c < 4, exp_d[c], exp_id[c], exp_occ[c]);
            end
        end

        // Requester 1 on alternate cycles: bubbles travel through uncompressed.
        for (int c = 0; c < 10; c++) begin
            logic [7:0] beat;
            logic       ov;
            beat = 8'((c / 2 + 1) * 8'h11);
            drive(1'b0, (c % 2 == 0) ? 4'h2 : 4'h0, {16'h0, beat, 8'h0}, 1'b1);
            if (c < 4) begin
                check($sformatf("bub%0d req_ready", c), 32'(req_ready),
                      (c % 2 == 0) ? 32'h2 : 32'h0);
            end else begin
                ov = (c % 2 == 0);
                check_all($sformatf("bub%0d", c), (c % 2 == 0) ? 4'h2 : 4'h0, ov,
                          ov ? 8'((((c - 4) / 2) + 1) * 8'h11) : 8'h00,
                          ov ? 2'd1 : 2'd0, 3'd2);
            end
        end

        drive(1'b1, 4'h0, 32'h0, 1'b1);

        // Single stage, single requester: beat visible right after its accept edge.
        drive1(1'b1, 8'h5A, 1'b1);
        check1("s1a", 1'b1, 1'b0, 8'h00, 1'b0);
        drive1(1'b1, 8'h6B, 1'b0);
        check1("s1b", 1'b0, 1'b1, 8'h5A, 1'b1);
        drive1(1'b1, 8'h6B, 1'b1);
        check1("s1c", 1'b1, 1'b1, 8'h5A, 1'b1);
        drive1(1'b0, 8'h00, 1'b1);
        check1("s1d", 1'b0, 1'b1, 8'h6B, 1'b1);
        drive1(1'b0, 8'h00, 1'b1);
        check1("s1e", 1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
